// File: rtl/scie_fir_multichannel.sv
// Multichannel SCIE FIR accelerator: CHANNELS filters of TAPS taps sharing one sequential MAC.
// Define FIR_SAT_EN to saturate results to the signed XLEN range instead of wrapping.
module scie_fir_multichannel #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TAPS     = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(TAPS)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_valid,
  output logic            io_ready,
  input  logic [31:0]     io_insn,
  input  logic [XLEN-1:0] io_rs1,
  input  logic [XLEN-1:0] io_rs2,
  output logic [XLEN-1:0] io_rd,
  output logic            io_rd_valid
);

  localparam int unsigned KW     = $clog2(TAPS);
  localparam int unsigned WIDE_W = (ACC_W > XLEN) ? ACC_W : XLEN;
  localparam int unsigned PROD_W = 2 * DATA_W;

  localparam logic [6:0] OpCoef = 7'h0B;
  localparam logic [6:0] OpPush = 7'h2B;
  localparam logic [6:0] OpRead = 7'h5B;
  localparam logic [6:0] OpCfg  = 7'h7B;

  localparam logic [5:0] ShiftMax = 6'(ACC_W - 1);

  typedef enum logic [1:0] {StIdle, StMac, StWb} state_e;

  state_e                   state_q, state_d;
  logic [KW-1:0]            k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [2:0]               ch_q, ch_d;

  logic signed [DATA_W-1:0] coef_q [CHANNELS][TAPS];
  logic signed [DATA_W-1:0] x_q    [CHANNELS][TAPS];
  logic [XLEN-1:0]          result_q [CHANNELS];
  logic [5:0]               shift_q;
  logic [XLEN-1:0]          rd_q;
  logic                     rd_valid_q;

  logic [6:0] opcode;
  logic [2:0] ch_idx;
  logic       ch_ok;
  logic       accept;
  logic       coef_we, push_we, cfg_we, rd_en;
  logic       result_we;

  assign opcode = io_insn[6:0];
  assign ch_idx = io_insn[14:12];
  assign ch_ok  = {1'b0, ch_idx} < 4'(CHANNELS);
  assign accept = io_valid && io_ready;

  assign coef_we = accept && (opcode == OpCoef) && ch_ok;
  assign push_we = accept && (opcode == OpPush) && ch_ok;
  assign cfg_we  = accept && (opcode == OpCfg) && ch_ok;
  // Reads bypass the busy handshake so software can poll results mid-computation.
  assign rd_en   = io_valid && (opcode == OpRead);

  assign io_ready    = (state_q == StIdle);
  assign io_rd       = rd_q;
  assign io_rd_valid = rd_valid_q;

  // Operand selection for the active tap of the latched channel
  logic signed [DATA_W-1:0] coef_sel, x_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  always_comb begin
    coef_sel = '0;
    x_sel    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        if (ch_q == 3'(c) && k_q == KW'(t)) begin
          coef_sel = coef_q[c][t];
          x_sel    = x_q[c][t];
        end
      end
    end
  end

  assign prod     = PROD_W'(coef_sel) * PROD_W'(x_sel);
  assign prod_ext = ACC_W'(prod);

  // Post-processing: arithmetic shift, then fit to XLEN
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [WIDE_W-1:0] acc_wide;
  logic [XLEN-1:0]          fit;

  assign acc_shr  = acc_q >>> shift_q;
  assign acc_wide = WIDE_W'(acc_shr);

`ifdef FIR_SAT_EN
  logic [WIDE_W-XLEN:0] acc_upper;
  assign acc_upper = acc_wide[WIDE_W-1:XLEN-1];
`endif

  always_comb begin
    fit = acc_wide[XLEN-1:0];
`ifdef FIR_SAT_EN
    // Upper bits not all equal means the value left the signed XLEN range
    if (!(&acc_upper) && (|acc_upper)) begin
      fit = acc_wide[WIDE_W-1] ? {1'b1, {(XLEN-1){1'b0}}} : {1'b0, {(XLEN-1){1'b1}}};
    end
`endif
  end

  logic [XLEN-1:0] rd_sel;

  always_comb begin
    rd_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (ch_idx == 3'(c)) rd_sel = result_q[c];
    end
  end

  // MAC sequencer
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    acc_d     = acc_q;
    ch_d      = ch_q;
    result_we = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (push_we) begin
          state_d = StMac;
          ch_d    = ch_idx;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        k_d   = k_q + KW'(1);
        if (k_q == KW'(TAPS - 1)) state_d = StWb;
      end
      StWb: begin
        result_we = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      acc_q   <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          coef_q[c][t] <= '0;
          x_q[c][t]    <= '0;
        end
        result_q[c] <= '0;
      end
      shift_q    <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_q <= rd_sel;
      if (cfg_we) shift_q <= (io_rs1[5:0] > ShiftMax) ? ShiftMax : io_rs1[5:0];
      for (int c = 0; c < CHANNELS; c++) begin
        if (ch_idx == 3'(c)) begin
          for (int t = 0; t < TAPS; t++) begin
            if (coef_we && io_rs2 == XLEN'(t)) coef_q[c][t] <= io_rs1[DATA_W-1:0];
          end
          if (push_we) begin
            x_q[c][0] <= io_rs1[DATA_W-1:0];
            for (int t = TAPS - 1; t > 0; t--) x_q[c][t] <= x_q[c][t-1];
          end
        end
        // Write-back uses the latched channel; a same-cycle read still sees the old value
        if (result_we && ch_q == 3'(c)) result_q[c] <= fit;
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{io_insn[31:15], io_insn[11:7], io_rs1[XLEN-1:DATA_W], acc_wide};

endmodule

// File: tb/tb_scie_fir_multichannel.sv
// Bench for scie_fir_multichannel: directed vector table, corner sequences, random vs model.
module tb_scie_fir_multichannel;

  localparam int XLEN     = 32;
  localparam int DATA_W   = 16;
  localparam int TAPS     = 5;
  localparam int CHANNELS = 4;
  localparam int ACC_W    = 2 * DATA_W + $clog2(TAPS);

  localparam logic [6:0] OpCoef  = 7'h0B;
  localparam logic [6:0] OpPush  = 7'h2B;
  localparam logic [6:0] OpRead  = 7'h5B;
  localparam logic [6:0] OpCfg   = 7'h7B;
  localparam logic [6:0] OpOther = 7'h13;

`ifdef FIR_SAT_EN
  localparam logic [31:0] BigExp = 32'h7FFFFFFF;
`else
  localparam logic [31:0] BigExp = 32'h3FFB0005;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            io_valid = 1'b0;
  logic            io_ready;
  logic [31:0]     io_insn = '0;
  logic [XLEN-1:0] io_rs1 = '0;
  logic [XLEN-1:0] io_rs2 = '0;
  logic [XLEN-1:0] io_rd;
  logic            io_rd_valid;

  scie_fir_multichannel dut (
    .clock      (clock),
    .reset      (reset),
    .io_valid   (io_valid),
    .io_ready   (io_ready),
    .io_insn    (io_insn),
    .io_rs1     (io_rs1),
    .io_rs2     (io_rs2),
    .io_rd      (io_rd),
    .io_rd_valid(io_rd_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  shortint     m_coef [CHANNELS][TAPS];
  shortint     m_x    [CHANNELS][TAPS];
  logic [31:0] m_res  [CHANNELS];
  int          m_shift;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  ch;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [6:0] op, logic [2:0] ch, logic [31:0] rs1,
                              logic [31:0] rs2, logic [31:0] exp);
    vec_t r;
    r.op = op; r.ch = ch; r.rs1 = rs1; r.rs2 = rs2; r.exp = exp;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CHANNELS; c++) begin
      for (int t = 0; t < TAPS; t++) begin
        m_coef[c][t] = 0;
        m_x[c][t]    = 0;
      end
      m_res[c] = '0;
    end
    m_shift = 0;
  endtask

  function automatic logic [31:0] model_result(input int ch);
    longint acc = 0;
    for (int t = 0; t < TAPS; t++) acc += longint'(m_coef[ch][t]) * longint'(m_x[ch][t]);
    acc = acc >>> m_shift;
`ifdef FIR_SAT_EN
    if (acc > 64'sd2147483647) return 32'h7FFFFFFF;
    if (acc < -64'sd2147483648) return 32'h80000000;
`endif
    return acc[31:0];
  endfunction

  task automatic model_apply(input logic [6:0] op, input int ch, input logic [31:0] rs1,
                             input logic [31:0] rs2);
    if (ch >= CHANNELS) return;
    case (op)
      OpCoef: if (rs2 < TAPS) m_coef[ch][rs2] = shortint'(rs1[15:0]);
      OpPush: begin
        for (int t = TAPS - 1; t > 0; t--) m_x[ch][t] = m_x[ch][t-1];
        m_x[ch][0] = shortint'(rs1[15:0]);
        m_res[ch]  = model_result(ch);
      end
      OpCfg:   m_shift = (int'(rs1[5:0]) > ACC_W - 1) ? ACC_W - 1 : int'(rs1[5:0]);
      default: ;
    endcase
  endtask

  task automatic set_insn(input logic [6:0] op, input int ch, input logic [31:0] rs1,
                          input logic [31:0] rs2);
    io_valid       = 1'b1;
    io_insn        = '0;
    io_insn[6:0]   = op;
    io_insn[14:12] = 3'(ch);
    io_rs1         = rs1;
    io_rs2         = rs2;
  endtask

  task automatic drive(input logic [6:0] op, input int ch, input logic [31:0] rs1,
                       input logic [31:0] rs2);
    set_insn(op, ch, rs1, rs2);
    @(posedge clock); #1;
    io_valid = 1'b0;
    io_insn  = '0;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (io_ready !== 1'b1 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check({name, "_ready"}, 32'(io_ready), 32'd1);
  endtask

  // Non-read command: waits for ready, applies, and for pushes checks the busy window length
  task automatic do_cmd(input logic [6:0] op, input int ch, input logic [31:0] rs1,
                        input logic [31:0] rs2, input string name);
    int busy = 0;
    wait_ready(name);
    drive(op, ch, rs1, rs2);
    model_apply(op, ch, rs1, rs2);
    if (op == OpPush) begin
      while (io_ready !== 1'b1 && busy < 40) begin
        busy++;
        @(posedge clock); #1;
      end
      check({name, "_busy"}, 32'(busy), (ch < CHANNELS) ? 32'(TAPS + 1) : 32'd0);
    end
  endtask

  task automatic do_read(input int ch, input logic [31:0] exp, input string name);
    drive(OpRead, ch, '0, '0);
    check({name, "_rdv"}, 32'(io_rd_valid), 32'd1);
    check({name, "_rd"}, io_rd, exp);
    @(posedge clock); #1;
    check({name, "_rdv_low"}, 32'(io_rd_valid), 32'd0);
    check({name, "_rd_hold"}, io_rd, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prev;
    model_reset();

    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd0));
    tbl.push_back(mk(OpCoef, 0, 4, 0, 0));
    tbl.push_back(mk(OpCoef, 0, 2, 1, 0));
    tbl.push_back(mk(OpCoef, 0, 5, 2, 0));
    tbl.push_back(mk(OpCoef, 0, 6, 3, 0));
    tbl.push_back(mk(OpCoef, 0, 3, 4, 0));
    tbl.push_back(mk(OpCoef, 0, 99, 5, 0));
    tbl.push_back(mk(OpPush, 0, 1, 0, 0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd4));
    tbl.push_back(mk(OpPush, 0, 2, 0, 0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd10));
    tbl.push_back(mk(OpPush, 0, 3, 0, 0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd21));
    tbl.push_back(mk(OpPush, 1, 7, 0, 0));
    tbl.push_back(mk(OpRead, 1, 0, 0, 32'd0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd21));
    tbl.push_back(mk(OpRead, 5, 0, 0, 32'd0));
    tbl.push_back(mk(OpCfg, 0, 2, 0, 0));
    tbl.push_back(mk(OpCoef, 2, 32'hFFFF, 0, 0));
    tbl.push_back(mk(OpPush, 2, 32'hFFFFFFF4, 0, 0));
    tbl.push_back(mk(OpRead, 2, 0, 0, 32'd3));
    tbl.push_back(mk(OpPush, 2, 5, 0, 0));
    tbl.push_back(mk(OpRead, 2, 0, 0, 32'hFFFFFFFE));
    tbl.push_back(mk(OpCfg, 0, 0, 0, 0));
    tbl.push_back(mk(OpCfg, 5, 9, 0, 0));
    for (int t = 0; t < TAPS; t++) tbl.push_back(mk(OpCoef, 3, 32'h7FFF, t, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(OpPush, 3, 32'h7FFF, 0, 0));
    tbl.push_back(mk(OpRead, 3, 0, 0, BigExp));
    tbl.push_back(mk(OpCfg, 0, 63, 0, 0));
    tbl.push_back(mk(OpPush, 2, 32'h7FFF, 0, 0));
    tbl.push_back(mk(OpRead, 2, 0, 0, 32'hFFFFFFFF));
    tbl.push_back(mk(OpCfg, 0, 0, 0, 0));
    tbl.push_back(mk(OpOther, 0, 55, 0, 0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd21));
    tbl.push_back(mk(OpPush, 7, 11, 0, 0));
    tbl.push_back(mk(OpRead, 0, 0, 0, 32'd21));

    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset_ready", 32'(io_ready), 32'd1);
    check("reset_rd", io_rd, 32'd0);
    check("reset_rdv", 32'(io_rd_valid), 32'd0);

    foreach (tbl[i]) begin
      if (tbl[i].op == OpRead) do_read(int'(tbl[i].ch), tbl[i].exp, $sformatf("vec%0d", i));
      else do_cmd(tbl[i].op, int'(tbl[i].ch), tbl[i].rs1, tbl[i].rs2, $sformatf("vec%0d", i));
    end

    // Ops issued while busy are dropped; a read mid-MAC returns the prior result
    wait_ready("drop_pre");
    prev = m_res[0];
    drive(OpPush, 0, 32'd1, '0);
    model_apply(OpPush, 0, 32'd1, '0);
    check("drop_busy", 32'(io_ready), 32'd0);
    set_insn(OpCoef, 0, 32'd100, 32'd0);
    @(posedge clock); #1;
    set_insn(OpCfg, 0, 32'd5, '0);
    @(posedge clock); #1;
    set_insn(OpPush, 0, 32'd9, '0);
    @(posedge clock); #1;
    set_insn(OpRead, 0, '0, '0);
    @(posedge clock); #1;
    io_valid = 1'b0;
    check("mac_read_rdv", 32'(io_rd_valid), 32'd1);
    check("mac_read_rd", io_rd, prev);
    @(posedge clock); #1;
    check("mac_read_rdv_low", 32'(io_rd_valid), 32'd0);
    wait_ready("drop_post");
    do_read(0, m_res[0], "drop_new");
    do_cmd(OpPush, 0, 32'd0, '0, "drop_repush");
    do_read(0, m_res[0], "drop_repush");

    // Read landing in the write-back cycle sees the old value
    wait_ready("wb_pre");
    prev = m_res[0];
    drive(OpPush, 0, 32'd2, '0);
    model_apply(OpPush, 0, 32'd2, '0);
    repeat (TAPS) begin @(posedge clock); #1; end
    check("wb_cycle_busy", 32'(io_ready), 32'd0);
    drive(OpRead, 0, '0, '0);
    check("wb_read_rd", io_rd, prev);
    check("wb_read_rdv", 32'(io_rd_valid), 32'd1);
    do_read(0, m_res[0], "wb_after");

    // Reset on the second MAC cycle abandons the computation
    wait_ready("rst_pre");
    drive(OpPush, 0, 32'd5, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check("rst_mid_ready", 32'(io_ready), 32'd1);
    check("rst_mid_rd", io_rd, 32'd0);
    check("rst_mid_rdv", 32'(io_rd_valid), 32'd0);
    do_read(0, 32'd0, "rst_mid_ch0");

    // Randomised traffic against the model
    for (int i = 0; i < 80; i++) begin
      int sel = $urandom_range(0, 4);
      int ch  = $urandom_range(0, 5);
      logic [31:0] rs1 = $urandom;
      logic [31:0] rs2 = 32'($urandom_range(0, 6));
      case (sel)
        0: do_cmd(OpCoef, ch, rs1, rs2, $sformatf("rnd%0d_coef", i));
        1: do_cmd(OpPush, ch, rs1, '0, $sformatf("rnd%0d_push", i));
        2: do_read(ch, (ch < CHANNELS) ? m_res[ch] : 32'd0, $sformatf("rnd%0d_read", i));
        3: do_cmd(OpCfg, ch, 32'($urandom_range(0, 40)), '0, $sformatf("rnd%0d_cfg", i));
        default: do_cmd(OpOther, ch, rs1, rs2, $sformatf("rnd%0d_other", i));
      endcase
    end
    for (int c = 0; c < 8; c++) do_read(c, (c < CHANNELS) ? m_res[c] : 32'd0,
                                        $sformatf("final_ch%0d", c));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
